// File: rtl/scan_pkg.sv
// Shared types for the scan-test controller.
// State encoding and capture-phase length.
package scan_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      CAPTURE = 3'd2,
      UNLOAD  = 3'd3,
      DONE    = 3'd4
   } scan_state_t;

   localparam int SCAN_CAPTURE_CYCLES = 1;

endpackage

// File: rtl/scan_ctrl.sv
// Tester-side scan controller: load, capture,
// unload, then masked compare against expected.
module scan_ctrl
   import scan_pkg::*;
#(
   parameter  int CHAIN_LEN = 3,
   localparam int CNT_W     = $clog2(CHAIN_LEN) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] pattern,
   input  logic [CHAIN_LEN-1:0] expected,
   input  logic [CHAIN_LEN-1:0] mask,
   output logic                 scan_en,
   output logic                 scan_in,
   input  logic                 scan_out,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] response,
   output logic [CHAIN_LEN-1:0] mismatch,
   output logic                 pass
);

   scan_state_t          state;
   logic [CNT_W-1:0]     cnt;
   logic [CHAIN_LEN-1:0] pat_q;
   logic [CHAIN_LEN-1:0] exp_q;
   logic [CHAIN_LEN-1:0] msk_q;
   logic [CHAIN_LEN-1:0] rsp_nxt;
   logic [CHAIN_LEN-1:0] mis_nxt;
   logic                 last;

   assign last    = (cnt == CNT_W'(CHAIN_LEN - 1));
   assign rsp_nxt = (response << 1) | CHAIN_LEN'(scan_out);
   assign mis_nxt = (rsp_nxt ^ exp_q) & msk_q;

   // MSB of the pattern shifter is the bit due on scan_in
   assign scan_en = (state == LOAD) || (state == UNLOAD);
   assign scan_in = (state == LOAD) && pat_q[CHAIN_LEN-1];
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);

   // Sequencer: phase counter, pattern shifter, response capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         pat_q    <= '0;
         exp_q    <= '0;
         msk_q    <= '0;
         response <= '0;
         mismatch <= '0;
         pass     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  pat_q    <= pattern;
                  exp_q    <= expected;
                  msk_q    <= mask;
                  cnt      <= '0;
                  response <= '0;
                  mismatch <= '0;
                  pass     <= 1'b0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               pat_q <= pat_q << 1;
               if (last) begin
                  cnt   <= '0;
                  state <= CAPTURE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CAPTURE: begin
               if (cnt == CNT_W'(SCAN_CAPTURE_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= UNLOAD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            UNLOAD: begin
               response <= rsp_nxt;
               if (last) begin
                  cnt      <= '0;
                  mismatch <= mis_nxt;
                  pass     <= (mis_nxt == '0);
                  state    <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl driving 3-cell and
// 8-cell behavioural scan chains.
module tb_scan_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       start3, se3, si3, so3, busy3, done3, pass3;
   logic [2:0] pat3, exp3, msk3, rsp3, mis3, d3, q3;

   logic       start8, se8, si8, so8, busy8, done8, pass8;
   logic [7:0] pat8, exp8, msk8, rsp8, mis8, d8, q8;

   assign so3 = q3[2];
   assign so8 = q8[7];

   scan_ctrl #(.CHAIN_LEN(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3),
      .pattern(pat3), .expected(exp3), .mask(msk3),
      .scan_en(se3), .scan_in(si3), .scan_out(so3),
      .busy(busy3), .done(done3), .response(rsp3),
      .mismatch(mis3), .pass(pass3)
   );

   scan_ctrl #(.CHAIN_LEN(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8),
      .pattern(pat8), .expected(exp8), .mask(msk8),
      .scan_en(se8), .scan_in(si8), .scan_out(so8),
      .busy(busy8), .done(done8), .response(rsp8),
      .mismatch(mis8), .pass(pass8)
   );

   // Chains: shift toward the last cell, else load functional d
   always @(posedge clk) begin
      q3 <= se3 ? {q3[1:0], si3} : d3;
      q8 <= se8 ? {q8[6:0], si8} : d8;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Called mid-cycle c0; returns the cycle in which done is seen
   task automatic wait_done(input bit sel, input int c0,
                            input int maxc, output int dc);
      int c;
      c  = c0;
      dc = -1;
      while (c <= maxc) begin
         if ((sel ? done8 : done3) === 1'b1) begin
            dc = c;
            break;
         end
         @(negedge clk);
         c++;
      end
      if (dc < 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=none required=done");
      end
   endtask

   // Start in cycle 0, return mid-cycle 1
   task automatic launch3(input logic [2:0] p, e, m, d);
      @(negedge clk);
      pat3   = p;
      exp3   = e;
      msk3   = m;
      d3     = d;
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
   endtask

   function automatic logic [31:0] idle3();
      return {25'd0, se3, si3, busy3, done3, pass3, rsp3 != 3'b0,
              mis3 != 3'b0};
   endfunction

   typedef struct {
      logic [2:0] pat;
      logic [2:0] exp;
      logic [2:0] msk;
      logic [2:0] d;
      logic [2:0] rsp;
      logic [2:0] mis;
      logic       pass;
   } vec_t;

   vec_t tbl[7];
   int   dc;
   int   ndone;
   int   dcs[3];

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{3'b101, 3'b110, 3'b111, 3'b110, 3'b110, 3'b000, 1'b1};
      tbl[1] = '{3'b101, 3'b011, 3'b111, 3'b110, 3'b110, 3'b101, 1'b0};
      tbl[2] = '{3'b101, 3'b011, 3'b010, 3'b110, 3'b110, 3'b000, 1'b1};
      tbl[3] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 1'b1};
      tbl[4] = '{3'b111, 3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 1'b0};
      tbl[5] = '{3'b010, 3'b101, 3'b110, 3'b111, 3'b111, 3'b010, 1'b0};
      tbl[6] = '{3'b110, 3'b000, 3'b011, 3'b100, 3'b100, 3'b000, 1'b1};

      pat3 = 3'b101; exp3 = 3'b110; msk3 = 3'b111; d3 = 3'b110;
      pat8 = 8'h00;  exp8 = 8'h00;  msk8 = 8'h00;  d8 = 8'h00;
      start3 = 1'b1;
      start8 = 1'b1;
      rst_n  = 1'b0;

      // Reset held with start asserted
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_hold", idle3(), 32'd0);
      end
      chk("reset_dut8", {se8, si8, busy8, done8, pass8}, 32'd0);
      start3 = 1'b0;
      start8 = 1'b0;
      rst_n  = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", idle3(), 32'd0);

      // Basic run with per-cycle scan_in and chain checks
      @(negedge clk);
      pat3 = 3'b101; exp3 = 3'b110; msk3 = 3'b111; d3 = 3'b110;
      start3 = 1'b1;
      chk("c0_se_busy", {se3, busy3}, 32'd0);
      @(negedge clk);
      start3 = 1'b0;
      chk("c1_se_si_busy", {se3, si3, busy3}, 32'b111);
      @(negedge clk);
      chk("c2_se_si", {se3, si3}, 32'b10);
      @(negedge clk);
      chk("c3_se_si", {se3, si3}, 32'b11);
      @(negedge clk);
      chk("c4_chain_loaded", q3, 32'b101);
      chk("c4_capture_se_si", {se3, si3}, 32'b00);
      @(negedge clk);
      chk("c5_chain_captured", q3, 32'b110);
      chk("c5_unload_se_si", {se3, si3}, 32'b10);
      wait_done(1'b0, 5, 40, dc);
      chk("basic_done_cycle", dc, 32'd8);
      chk("basic_response", rsp3, 32'b110);
      chk("basic_mismatch", mis3, 32'b000);
      chk("basic_pass", pass3, 32'd1);
      chk("basic_done_se_busy", {se3, busy3}, 32'b01);
      @(negedge clk);
      chk("c9_idle", {busy3, done3}, 32'd0);
      chk("c9_hold_response", rsp3, 32'b110);

      // Table of runs on the 3-cell chain
      foreach (tbl[i]) begin
         launch3(tbl[i].pat, tbl[i].exp, tbl[i].msk, tbl[i].d);
         wait_done(1'b0, 1, 40, dc);
         chk($sformatf("vec%0d_done_cycle", i), dc, 32'd8);
         chk($sformatf("vec%0d_response", i), rsp3, tbl[i].rsp);
         chk($sformatf("vec%0d_mismatch", i), mis3, tbl[i].mis);
         chk($sformatf("vec%0d_pass", i), pass3, tbl[i].pass);
      end

      // Start pulses in LOAD and DONE are ignored
      launch3(3'b101, 3'b110, 3'b111, 3'b110);
      ndone = 0;
      dc    = -1;
      for (int c = 1; c <= 20; c++) begin
         if (done3 === 1'b1) begin
            ndone++;
            if (dc < 0) dc = c;
         end
         start3 = (c == 3) || (c == 8);
         @(negedge clk);
      end
      start3 = 1'b0;
      chk("ignored_start_ndone", ndone, 32'd1);
      chk("ignored_start_cycle", dc, 32'd8);
      chk("ignored_start_idle", busy3, 32'd0);

      // Start held high: back-to-back runs
      @(negedge clk);
      start3 = 1'b1;
      ndone  = 0;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk);
         if (done3 === 1'b1) begin
            if (ndone < 3) dcs[ndone] = c;
            ndone++;
         end
         if (c == 27) start3 = 1'b0;
      end
      chk("held_ndone", ndone, 32'd3);
      chk("held_done0", dcs[0], 32'd8);
      chk("held_done1", dcs[1], 32'd17);
      chk("held_done2", dcs[2], 32'd26);

      // Reset during UNLOAD
      launch3(3'b101, 3'b110, 3'b111, 3'b110);
      repeat (5) @(negedge clk);
      chk("c6_unloading", {se3, rsp3}, 32'b1001);
      rst_n  = 1'b0;
      start3 = 1'b1;
      #1;
      chk("midrun_reset_now", idle3(), 32'd0);
      ndone = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done3 !== 1'b0) ndone++;
         chk("midrun_reset_hold", idle3(), 32'd0);
      end
      chk("midrun_no_done", ndone, 32'd0);
      rst_n  = 1'b1;
      start3 = 1'b0;
      launch3(3'b101, 3'b110, 3'b111, 3'b110);
      wait_done(1'b0, 1, 40, dc);
      chk("rerun_done_cycle", dc, 32'd8);
      chk("rerun_response", rsp3, 32'b110);
      chk("rerun_pass", pass3, 32'd1);

      // 8-cell chain
      @(negedge clk);
      pat8 = 8'hA5; exp8 = 8'h3C; msk8 = 8'hFF; d8 = 8'h3C;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      chk("n8_c1_si", si8, 32'd1);
      repeat (8) @(negedge clk);
      chk("n8_chain_loaded", q8, 32'hA5);
      wait_done(1'b1, 9, 60, dc);
      chk("n8_done_cycle", dc, 32'd18);
      chk("n8_response", rsp8, 32'h3C);
      chk("n8_mismatch", mis8, 32'h00);
      chk("n8_pass", pass8, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
